// File: rtl/butterfly_pkg.sv
// Shared definitions for the radix-2 handshake butterfly: FSM states,
// product slot indices and width-parametrised range/saturation helpers.
package butterfly_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] P_RR = 2'd0;
    localparam logic [1:0] P_II = 2'd1;
    localparam logic [1:0] P_RI = 2'd2;
    localparam logic [1:0] P_IR = 2'd3;

    function automatic logic fits_width(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic signed [63:0] saturate_width(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fx_mul_round.sv
// Registered signed fixed-point multiply: full product, round half up,
// arithmetic shift right by FRACTION. Output updates only when i_en is high.
module fx_mul_round
    import butterfly_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int FRACTION  = 8
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_en,
    input  logic signed [WORD_SIZE-1:0]           i_a,
    input  logic signed [WORD_SIZE-1:0]           i_b,
    output logic signed [2*WORD_SIZE-FRACTION-1:0] o_p
);

    localparam int PW = 2 * WORD_SIZE - FRACTION;
    localparam logic signed [2*WORD_SIZE-1:0] HALF =
        {{(2*WORD_SIZE-1){1'b0}}, 1'b1} << (FRACTION - 1);

    logic signed [2*WORD_SIZE-1:0] full;
    logic signed [2*WORD_SIZE-1:0] rounded;
    logic signed [PW-1:0]          p_d;
    logic signed [PW-1:0]          p_q;

    // The biased full product cannot overflow 2*WORD_SIZE bits, so the
    // shifted value always fits in PW bits.
    always_comb begin
        full    = i_a * i_b;
        rounded = full + HALF;
        p_d     = i_en ? PW'(rounded >>> FRACTION) : p_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) p_q <= '0;
        else          p_q <= p_d;
    end

    assign o_p = p_q;

endmodule

// File: rtl/butterfly_r2_hs.sv
// Radix-2 DIT butterfly with valid/ready handshakes and a shared multiplier.
// Define BUTTERFLY_SATURATE_EN to clamp out-of-range results instead of wrapping.
module butterfly_r2_hs
    import butterfly_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int FRACTION  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WORD_SIZE-1:0] i_in0_re,
    input  logic [WORD_SIZE-1:0] i_in0_im,
    input  logic [WORD_SIZE-1:0] i_in1_re,
    input  logic [WORD_SIZE-1:0] i_in1_im,
    input  logic [WORD_SIZE-1:0] i_twiddle_re,
    input  logic [WORD_SIZE-1:0] i_twiddle_im,
    input  logic                 i_inverse,
    input  logic                 i_scale,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WORD_SIZE-1:0] o_out0_re,
    output logic [WORD_SIZE-1:0] o_out0_im,
    output logic [WORD_SIZE-1:0] o_out1_re,
    output logic [WORD_SIZE-1:0] o_out1_im,
    output logic                 o_overflow,
    output logic                 o_busy
);

    localparam int PW = 2 * WORD_SIZE - FRACTION;
    localparam int IW = PW + 2;
    localparam logic signed [WORD_SIZE-1:0] MIN_W = {1'b1, {(WORD_SIZE-1){1'b0}}};
    localparam logic signed [WORD_SIZE-1:0] MAX_W = ~MIN_W;

    state_t                      state_q, state_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic signed [WORD_SIZE-1:0] in0_re_q, in0_re_d, in0_im_q, in0_im_d;
    logic signed [WORD_SIZE-1:0] in1_re_q, in1_re_d, in1_im_q, in1_im_d;
    logic signed [WORD_SIZE-1:0] tw_re_q, tw_re_d, tw_im_q, tw_im_d;
    logic                        inverse_q, inverse_d, scale_q, scale_d;
    logic signed [PW-1:0]        prod_q [0:2];
    logic signed [PW-1:0]        prod_d [0:2];
    logic [WORD_SIZE-1:0]        out_q [4];
    logic [WORD_SIZE-1:0]        out_d [4];
    logic                        ovf_q, ovf_d, valid_q, valid_d;
    logic                        ready_q, ready_d, busy_q, busy_d;

    logic signed [WORD_SIZE-1:0] tw_im_eff, mul_a, mul_b;
    logic signed [PW-1:0]        mul_p;
    logic signed [IW-1:0]        t_re, t_im;
    logic signed [IW-1:0]        res [4];
    logic                        res_ovf;

    // Conjugation saturates the single unrepresentable negation.
    always_comb begin
        tw_im_eff = tw_im_q;
        if (inverse_q) tw_im_eff = (tw_im_q == MIN_W) ? MAX_W : -tw_im_q;
        mul_a = (cnt_q == P_RR || cnt_q == P_RI) ? in1_re_q : in1_im_q;
        mul_b = (cnt_q == P_RR || cnt_q == P_IR) ? tw_re_q : tw_im_eff;
    end

    fx_mul_round #(.WORD_SIZE(WORD_SIZE), .FRACTION(FRACTION)) u_mul (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (state_q == ST_MUL),
        .i_a     (mul_a),
        .i_b     (mul_b),
        .o_p     (mul_p)
    );

    // In ADD the last product (in1_im*tw_re) is still in the multiplier register.
    always_comb begin
        t_re   = IW'(prod_q[P_RR]) - IW'(prod_q[P_II]);
        t_im   = IW'(prod_q[P_RI]) + IW'(mul_p);
        res[0] = IW'(in0_re_q) + t_re;
        res[1] = IW'(in0_im_q) + t_im;
        res[2] = IW'(in0_re_q) - t_re;
        res[3] = IW'(in0_im_q) - t_im;
        res_ovf = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (scale_q) res[k] = res[k] >>> 1;
            if (!fits_width(64'(res[k]), WORD_SIZE)) res_ovf = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in0_re_d  = in0_re_q;
        in0_im_d  = in0_im_q;
        in1_re_d  = in1_re_q;
        in1_im_d  = in1_im_q;
        tw_re_d   = tw_re_q;
        tw_im_d   = tw_im_q;
        inverse_d = inverse_q;
        scale_d   = scale_q;
        prod_d    = prod_q;
        out_d     = out_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    in0_re_d  = i_in0_re;
                    in0_im_d  = i_in0_im;
                    in1_re_d  = i_in1_re;
                    in1_im_d  = i_in1_im;
                    tw_re_d   = i_twiddle_re;
                    tw_im_d   = i_twiddle_im;
                    inverse_d = i_inverse;
                    scale_d   = i_scale;
                    cnt_d     = 2'd0;
                    state_d   = ST_MUL;
                end
            end
            ST_MUL: begin
                if (cnt_q != 2'd0) prod_d[cnt_q - 2'd1] = mul_p;
                if (cnt_q == 2'd3) state_d = ST_ADD;
                else               cnt_d   = cnt_q + 2'd1;
            end
            ST_ADD: begin
                for (int k = 0; k < 4; k++) begin
`ifdef BUTTERFLY_SATURATE_EN
                    out_d[k] = WORD_SIZE'(saturate_width(64'(res[k]), WORD_SIZE));
`else
                    out_d[k] = res[k][WORD_SIZE-1:0];
`endif
                end
                ovf_d   = res_ovf;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (i_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            in0_re_q  <= '0;
            in0_im_q  <= '0;
            in1_re_q  <= '0;
            in1_im_q  <= '0;
            tw_re_q   <= '0;
            tw_im_q   <= '0;
            inverse_q <= 1'b0;
            scale_q   <= 1'b0;
            for (int k = 0; k < 3; k++) prod_q[k] <= '0;
            for (int k = 0; k < 4; k++) out_q[k] <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in0_re_q  <= in0_re_d;
            in0_im_q  <= in0_im_d;
            in1_re_q  <= in1_re_d;
            in1_im_q  <= in1_im_d;
            tw_re_q   <= tw_re_d;
            tw_im_q   <= tw_im_d;
            inverse_q <= inverse_d;
            scale_q   <= scale_d;
            prod_q    <= prod_d;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_busy     = busy_q;
    assign o_overflow = ovf_q;
    assign o_out0_re  = out_q[0];
    assign o_out0_im  = out_q[1];
    assign o_out1_re  = out_q[2];
    assign o_out1_im  = out_q[3];

endmodule

// File: tb/tb_butterfly_r2_hs.sv
// Self-checking bench for butterfly_r2_hs: directed cases plus random
// transactions compared against an integer-arithmetic reference model.
module tb_butterfly_r2_hs;

    localparam int W = 16;
    localparam int F = 8;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b1;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b0;
    logic         i_inverse = 1'b0;
    logic         i_scale = 1'b0;
    logic [W-1:0] i_in0_re = '0, i_in0_im = '0, i_in1_re = '0, i_in1_im = '0;
    logic [W-1:0] i_twiddle_re = '0, i_twiddle_im = '0;
    logic         o_ready, o_valid, o_overflow, o_busy;
    logic [W-1:0] o_out0_re, o_out0_im, o_out1_re, o_out1_im;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_o [4];
    logic         exp_ovf;

    always #5 i_clk = ~i_clk;

    butterfly_r2_hs #(.WORD_SIZE(W), .FRACTION(F)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_in0_re     (i_in0_re),
        .i_in0_im     (i_in0_im),
        .i_in1_re     (i_in1_re),
        .i_in1_im     (i_in1_im),
        .i_twiddle_re (i_twiddle_re),
        .i_twiddle_im (i_twiddle_im),
        .i_inverse    (i_inverse),
        .i_scale      (i_scale),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_out0_re    (o_out0_re),
        .o_out0_im    (o_out0_im),
        .o_out1_re    (o_out1_re),
        .o_out1_im    (o_out1_im),
        .o_overflow   (o_overflow),
        .o_busy       (o_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic longint rnd(input longint x);
        return (x + (longint'(1) <<< (F - 1))) >>> F;
    endfunction

    // Butterfly evaluated with plain 64-bit integers from the current inputs.
    task automatic refModel();
        longint a0r, a0i, a1r, a1i, wr, wi, tr, ti, lim;
        longint r [4];
        a0r = longint'($signed(i_in0_re));  a0i = longint'($signed(i_in0_im));
        a1r = longint'($signed(i_in1_re));  a1i = longint'($signed(i_in1_im));
        wr  = longint'($signed(i_twiddle_re));
        wi  = longint'($signed(i_twiddle_im));
        if (i_inverse) wi = (wi == -32768) ? 32767 : -wi;
        tr = rnd(a1r * wr) - rnd(a1i * wi);
        ti = rnd(a1r * wi) + rnd(a1i * wr);
        r[0] = a0r + tr;  r[1] = a0i + ti;
        r[2] = a0r - tr;  r[3] = a0i - ti;
        lim = longint'(1) <<< (W - 1);
        exp_ovf = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (i_scale) r[k] = r[k] >>> 1;
            if (r[k] >= lim || r[k] < -lim) begin
                exp_ovf = 1'b1;
`ifdef BUTTERFLY_SATURATE_EN
                r[k] = (r[k] >= lim) ? lim - 1 : -lim;
`endif
            end
            exp_o[k] = r[k][W-1:0];
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a0r, a0i, a1r, a1i, wr, wi,
                                 input logic inv, input logic scl);
        int n;
        n = 0;
        while (!o_ready && n < 50) begin
            @(posedge i_clk); #1; n++;
        end
        check("ready_before_accept", {63'd0, o_ready}, 64'd1);
        i_in0_re = a0r;  i_in0_im = a0i;  i_in1_re = a1r;  i_in1_im = a1i;
        i_twiddle_re = wr;  i_twiddle_im = wi;
        i_inverse = inv;  i_scale = scl;
        refModel();
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        // Scramble operands to prove they were latched at accept.
        i_in0_re = W'($urandom);  i_in0_im = W'($urandom);
        i_in1_re = W'($urandom);  i_in1_im = W'($urandom);
        i_twiddle_re = W'($urandom);  i_twiddle_im = W'($urandom);
        i_inverse = ~inv;  i_scale = ~scl;
    endtask

    task automatic checkOutput(input string tag);
        int n;
        n = 0;
        while (!o_valid && n < 20) begin
            @(posedge i_clk); #1; n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd5);
        check({tag, "_out0_re"}, 64'(o_out0_re), 64'(exp_o[0]));
        check({tag, "_out0_im"}, 64'(o_out0_im), 64'(exp_o[1]));
        check({tag, "_out1_re"}, 64'(o_out1_re), 64'(exp_o[2]));
        check({tag, "_out1_im"}, 64'(o_out1_im), 64'(exp_o[3]));
        check({tag, "_ovf"}, {63'd0, o_overflow}, {63'd0, exp_ovf});
        check({tag, "_ready_low"}, {63'd0, o_ready}, 64'd0);
        check({tag, "_busy"}, {63'd0, o_busy}, 64'd1);
    endtask

    task automatic releaseResult(input string tag);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        check({tag, "_valid_drop"}, {63'd0, o_valid}, 64'd0);
        check({tag, "_ready_rise"}, {63'd0, o_ready}, 64'd1);
    endtask

    initial begin
        logic [W-1:0] held [4];
        logic         seen_valid;
        #2 i_rst_n = 1'b0;
        #1;
        check("rst_ready", {63'd0, o_ready}, 64'd1);
        check("rst_valid", {63'd0, o_valid}, 64'd0);
        check("rst_busy", {63'd0, o_busy}, 64'd0);
        check("rst_ovf", {63'd0, o_overflow}, 64'd0);
        check("rst_out0_re", 64'(o_out0_re), 64'd0);
        @(negedge i_clk) i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        applyStimulus(16'h0100, 16'h0000, 16'h0080, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0);
        checkOutput("real");
        check("real_const_out0_re", 64'(o_out0_re), 64'h0180);
        check("real_const_out1_re", 64'(o_out1_re), 64'h0080);
        releaseResult("real");

        applyStimulus(16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'hFF00, 1'b0, 1'b0);
        checkOutput("tw_fwd");
        check("tw_fwd_const_out0_im", 64'(o_out0_im), 64'hFF00);
        check("tw_fwd_const_out1_im", 64'(o_out1_im), 64'h0100);
        releaseResult("tw_fwd");

        applyStimulus(16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'hFF00, 1'b1, 1'b0);
        checkOutput("tw_inv");
        check("tw_inv_const_out0_im", 64'(o_out0_im), 64'h0100);
        releaseResult("tw_inv");

        applyStimulus(16'h0200, 16'h0000, 16'h0200, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b1);
        checkOutput("scale");
        check("scale_const_out0_re", 64'(o_out0_re), 64'h0200);
        releaseResult("scale");

        applyStimulus(16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0);
        checkOutput("ovf");
        check("ovf_const_flag", {63'd0, o_overflow}, 64'd1);
`ifdef BUTTERFLY_SATURATE_EN
        check("ovf_const_out0_re", 64'(o_out0_re), 64'h7FFF);
`else
        check("ovf_const_out0_re", 64'(o_out0_re), 64'hFE00);
`endif

        // Backpressure on the overflow result: DONE must hold for 3 cycles.
        held[0] = o_out0_re;  held[1] = o_out0_im;  held[2] = o_out1_re;  held[3] = o_out1_im;
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk); #1;
            check("bp_valid", {63'd0, o_valid}, 64'd1);
            check("bp_ready", {63'd0, o_ready}, 64'd0);
            check("bp_out0_re", 64'(o_out0_re), 64'(held[0]));
            check("bp_out1_im", 64'(o_out1_im), 64'(held[3]));
        end
        releaseResult("bp");

        applyStimulus(16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h8000, 1'b1, 1'b0);
        checkOutput("corner_min");
        releaseResult("corner_min");

        // Reset in the middle of MUL abandons the transaction.
        applyStimulus(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        #1;
        check("midrst_ready", {63'd0, o_ready}, 64'd1);
        check("midrst_busy", {63'd0, o_busy}, 64'd0);
        @(negedge i_clk) i_rst_n = 1'b1;
        i_ready = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge i_clk); #1;
            if (o_valid) seen_valid = 1'b1;
        end
        i_ready = 1'b0;
        check("midrst_no_valid", {63'd0, seen_valid}, 64'd0);
        check("midrst_ready_after", {63'd0, o_ready}, 64'd1);

        for (int t = 0; t < 40; t++) begin
            applyStimulus(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                          W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            checkOutput("rand");
            releaseResult("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
